tx_sequencer_1553: RTL and testbench

TX_SEQUENCER_1553 -- requirements
Module: tx_sequencer_1553

---
 rtl/tx_sequencer_1553_pkg.sv | 25 ++
 rtl/tx_sequencer_1553_slot_timer.sv | 21 ++
 rtl/tx_sequencer_1553.sv | 145 ++++++++++++++
 tb/tb_tx_sequencer_1553.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sequencer_1553_pkg.sv
// Shared types and constants for the 1553 transmit sequencer.
package tx_sequencer_1553_pkg;

  localparam int WORD_CLKS = 40;
  localparam int MAX_WC    = 32;
  localparam int STATE_W   = 3;
  localparam int TMR_W     = 6;
  localparam int REM_W     = 6;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    GAP,
    SEND_SW,
    WAIT_SW,
    SEND_DW,
    WAIT_DW,
    DONE
  } state_e;

  // A word count of 0 on the bus means a full 32-word message.
  function automatic logic [REM_W-1:0] wc_to_rem(input logic [4:0] wc);
    return (wc == 5'd0) ? REM_W'(MAX_WC) : {1'b0, wc};
  endfunction

endpackage

// File: rtl/tx_sequencer_1553_slot_timer.sv
// Loadable down-counter that parks at zero; times both the response gap and word slots.
module tx_slot_timer #(
  parameter int W = 6
) (
  input  logic         enc_clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n)              value <= '0;
    else if (load)           value <= load_val;
    else if (value != '0)    value <= value - 1'b1;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/tx_sequencer_1553.sv
// Sequences one status word plus its data words onto the 1553 encoder, pacing
// strobes on the slot timer and prefetching each data word from the FIFO.
module tx_sequencer_1553
  import tx_sequencer_1553_pkg::*;
(
  input  logic        enc_clk,
  input  logic        rst_n,
  input  logic        msg_start,
  input  logic [0:15] msg_status,
  input  logic [4:0]  msg_wc,
  input  logic [4:0]  msg_gap,
  input  logic        abort,
  output logic        dw_rd,
  input  logic [0:15] dw_data,
  input  logic        dw_empty,
  output logic [0:15] tx_dword,
  output logic        tx_csw,
  output logic        tx_dw,
  input  logic        tx_busy,
  output logic        msg_busy,
  output logic        msg_done,
  output logic        msg_err
);

  state_e             state, state_d;
  logic [0:15]        status_q, hold_q, dword_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               err_q, err_d;
  logic               first_q, cap_q;
  logic               lat_ld, dword_ld, tmr_ld;
  logic [TMR_W-1:0]   tmr_val, t_val;
  logic               t_zero, t_last;

  tx_slot_timer #(.W(TMR_W)) u_timer (
    .enc_clk  (enc_clk),
    .rst_n    (rst_n),
    .load     (tmr_ld),
    .load_val (tmr_val),
    .value    (t_val),
    .zero     (t_zero)
  );

  // The slot expires on the edge where the timer reaches zero, so a word
  // slot of WORD_CLKS-1 waiting cycles plus the strobe cycle gives exact pacing.
  assign t_last = t_zero | (t_val == TMR_W'(1));

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      status_q <= '0;
      hold_q   <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      cap_q    <= 1'b0;
      tx_dword <= '0;
    end else begin
      state   <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      first_q <= (state == SEND_SW) || (state == SEND_DW);
      cap_q   <= dw_rd;
      if (lat_ld)   status_q <= msg_status;
      if (cap_q)    hold_q   <= dw_data;
      if (dword_ld) tx_dword <= dword_d;
    end
  end

  always_comb begin
    state_d  = state;
    rem_d    = rem_q;
    err_d    = err_q;
    lat_ld   = 1'b0;
    tmr_ld   = 1'b0;
    tmr_val  = '0;
    dword_ld = 1'b0;
    dword_d  = hold_q;
    dw_rd    = 1'b0;
    unique case (state)
      IDLE: begin
        if (msg_start) begin
          lat_ld = 1'b1;
          rem_d  = wc_to_rem(msg_wc);
          err_d  = 1'b0;
          if (msg_gap == 5'd0) begin
            state_d  = SEND_SW;
            dword_ld = 1'b1;
            dword_d  = msg_status;
          end else begin
            state_d = GAP;
            tmr_ld  = 1'b1;
            tmr_val = TMR_W'(msg_gap);
          end
        end
      end
      GAP: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (t_last) begin
          state_d  = SEND_SW;
          dword_ld = 1'b1;
          dword_d  = status_q;
        end
      end
      SEND_SW: begin
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(WORD_CLKS - 1);
        state_d = WAIT_SW;
      end
      SEND_DW: begin
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(WORD_CLKS - 1);
        rem_d   = (rem_q != '0) ? rem_q - 1'b1 : '0;
        state_d = WAIT_DW;
      end
      WAIT_SW, WAIT_DW: begin
        // Prefetch the next word at the top of the slot; an empty FIFO here is an underrun.
        if (first_q && rem_q != '0) begin
          if (!dw_empty) dw_rd = 1'b1;
          else           err_d = 1'b1;
        end
        if (abort) err_d = 1'b1;
        if (t_last && !tx_busy) begin
          if (rem_q != '0 && !err_q && !abort) begin
            state_d  = SEND_DW;
            dword_ld = 1'b1;
            dword_d  = hold_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tx_csw   = (state == SEND_SW);
  assign tx_dw    = (state == SEND_DW);
  assign msg_done = (state == DONE);
  assign msg_err  = msg_done & err_q;
  assign msg_busy = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_tx_sequencer_1553.sv
// Randomized bench for tx_sequencer_1553 against a message-level timeline model.
module tb_tx_sequencer_1553;

  localparam int WORD_CLKS = 40;
  localparam int FDEPTH    = 4096;

  logic        enc_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_start = 1'b0;
  logic [0:15] msg_status = '0;
  logic [4:0]  msg_wc = '0;
  logic [4:0]  msg_gap = '0;
  logic        abort = 1'b0;
  logic        dw_rd;
  logic [0:15] dw_data = '0;
  logic        dw_empty;
  logic [0:15] tx_dword;
  logic        tx_csw, tx_dw, tx_busy;
  logic        msg_busy, msg_done, msg_err;

  tx_sequencer_1553 dut (
    .enc_clk(enc_clk), .rst_n(rst_n), .msg_start(msg_start), .msg_status(msg_status),
    .msg_wc(msg_wc), .msg_gap(msg_gap), .abort(abort), .dw_rd(dw_rd), .dw_data(dw_data),
    .dw_empty(dw_empty), .tx_dword(tx_dword), .tx_csw(tx_csw), .tx_dw(tx_dw),
    .tx_busy(tx_busy), .msg_busy(msg_busy), .msg_done(msg_done), .msg_err(msg_err)
  );

  always #5 enc_clk = ~enc_clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  always @(posedge enc_clk) cyc <= cyc + 1;

  // FIFO model: data one cycle after the read strobe
  logic [15:0] fifo_mem [FDEPTH];
  int rd_ptr = 0, wr_ptr = 0;
  assign dw_empty = (rd_ptr == wr_ptr);
  always @(posedge enc_clk) begin
    if (dw_rd) begin
      dw_data <= fifo_mem[rd_ptr % FDEPTH];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // encoder model: busy for busy_len cycles starting the cycle after tx_dw
  int busy_len = 10, busy_cnt = 0;
  always @(posedge enc_clk) begin
    if (tx_dw)             busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0);

  // monitor
  int          csw_t[$], dw_t[$], done_t[$];
  logic [15:0] csw_w[$], dw_w[$];
  logic        done_e[$];
  int          rd_n = 0, busy_n = 0, ovl_n = 0, hold_n = 0;
  logic [15:0] last_word = '0;
  always @(negedge enc_clk) begin
    if (tx_csw)   begin csw_t.push_back(cyc); csw_w.push_back(tx_dword); end
    if (tx_dw)    begin dw_t.push_back(cyc);  dw_w.push_back(tx_dword);  end
    if (msg_done) begin done_t.push_back(cyc); done_e.push_back(msg_err); end
    if (dw_rd)    rd_n <= rd_n + 1;
    if (msg_busy) busy_n <= busy_n + 1;
    if (tx_csw && tx_dw) ovl_n <= ovl_n + 1;
    if (!tx_csw && !tx_dw && tx_dword !== last_word) hold_n <= hold_n + 1;
    last_word <= tx_dword;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge enc_clk);
    #1;
  endtask

  // abort_at / poke_at are cycles relative to msg_start; <0 or 0 disables them
  task automatic run_msg(input string nm, input logic [15:0] st, input int wc, input int gap,
                         input int nfifo, input int blen, input int abort_at, input int poke_at);
    logic [15:0] data[$];
    int          e_dw_t[$];
    logic [15:0] e_dw_w[$];
    int t0, a, wce, s, e, rem, avail, k, e_csw_t, e_done, e_rd, guard, nd;
    int b_csw, b_dw, b_done, b_rd, b_busy, b_ovl, b_hold;
    bit e_err, underrun, ab, lastdw, have_csw;

    for (int i = 0; i < nfifo; i++) begin
      data.push_back(16'($urandom));
      fifo_mem[(rd_ptr + i) % FDEPTH] = data[i];
    end
    wr_ptr = rd_ptr + nfifo;
    b_csw = csw_t.size(); b_dw = dw_t.size(); b_done = done_t.size();
    b_rd = rd_n; b_busy = busy_n; b_ovl = ovl_n; b_hold = hold_n;

    msg_status = st; msg_wc = 5'(wc); msg_gap = 5'(gap); busy_len = blen;
    msg_start = 1'b1;
    t0 = cyc;

    // reference timeline
    wce = (wc == 0) ? 32 : wc;
    a = (abort_at > 0) ? t0 + abort_at : 32'h3fff_ffff;
    e_rd = 0; e_err = 1'b0; have_csw = 1'b0; e_csw_t = 0;
    if (gap > 0 && a <= t0 + gap) begin
      e_done = a + 1;
      e_err  = 1'b1;
    end else begin
      s = t0 + 1 + gap; e_csw_t = s; have_csw = 1'b1;
      rem = wce; avail = nfifo; k = 0; lastdw = 1'b0;
      for (int n = 0; n <= wce; n++) begin
        e = s + WORD_CLKS - 1;
        if (lastdw && s + blen + 1 > e) e = s + blen + 1;
        underrun = 1'b0;
        if (rem > 0) begin
          if (avail > 0) begin avail--; e_rd++; end
          else underrun = 1'b1;
        end
        ab = (a <= e);
        if (rem > 0 && !underrun && !ab) begin
          s = e + 1;
          e_dw_t.push_back(s); e_dw_w.push_back(data[k]);
          k++; rem--; lastdw = 1'b1;
        end else begin
          e_done = e + 1;
          e_err  = underrun | ab;
          break;
        end
      end
    end

    guard = 0;
    do begin
      tick();
      guard++;
      msg_start = 1'b0;
      if (guard == 1) begin
        msg_status = 16'($urandom); msg_wc = 5'($urandom); msg_gap = 5'($urandom);
      end
      if (abort_at > 0 && cyc == t0 + abort_at) abort = 1'b1;
      if (poke_at > 0 && cyc == t0 + poke_at && cyc < e_done) begin
        msg_start = 1'b1; msg_status = ~st; msg_wc = 5'd1; msg_gap = 5'd0;
      end
    end while (done_t.size() == b_done && guard < 3000);
    msg_start = 1'b0;
    abort = 1'b0;
    if (guard >= 3000) chk({nm, ":timeout"}, 0, 1);
    repeat (60) tick();

    chk({nm, ":csw_n"}, csw_t.size() - b_csw, have_csw);
    if (have_csw && csw_t.size() > b_csw) begin
      chk({nm, ":csw_t"}, csw_t[b_csw] - t0, e_csw_t - t0);
      chk({nm, ":csw_w"}, csw_w[b_csw], st);
    end
    nd = dw_t.size() - b_dw;
    chk({nm, ":dw_n"}, nd, e_dw_t.size());
    for (int i = 0; i < nd && i < e_dw_t.size(); i++) begin
      chk($sformatf("%s:dw_t%0d", nm, i), dw_t[b_dw + i] - t0, e_dw_t[i] - t0);
      chk($sformatf("%s:dw_w%0d", nm, i), dw_w[b_dw + i], e_dw_w[i]);
    end
    chk({nm, ":done_n"}, done_t.size() - b_done, 1);
    if (done_t.size() > b_done) begin
      chk({nm, ":done_t"}, done_t[b_done] - t0, e_done - t0);
      chk({nm, ":err"}, done_e[b_done], e_err);
    end
    chk({nm, ":rd_n"}, rd_n - b_rd, e_rd);
    chk({nm, ":busy_n"}, busy_n - b_busy, e_done - t0 - 1);
    chk({nm, ":overlap"}, ovl_n - b_ovl, 0);
    chk({nm, ":hold"}, hold_n - b_hold, 0);
  endtask

  initial begin
    int wc, wce, gap, nf, bl, ab, pk, guard, b_csw, b_dw, b_done, b_rd;
    repeat (3) tick();
    chk("rst_outs", {26'd0, dw_rd, tx_csw, tx_dw, msg_busy, msg_done, msg_err}, 0);
    chk("rst_dword", tx_dword, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    run_msg("basic",   16'h0800, 2, 0, 2, 20, -1, 0);
    run_msg("wc32",    16'h1234, 0, 0, 32, 30, -1, 0);
    run_msg("gap10",   16'habcd, 1, 10, 1, 5, -1, 0);
    run_msg("underrun",16'h5555, 3, 0, 1, 15, -1, 0);
    run_msg("abort_dw",16'h0f0f, 4, 0, 4, 25, 1 + WORD_CLKS + 20, 30);
    run_msg("abort_gap",16'h7e7e, 2, 15, 2, 10, 5, 3);
    run_msg("busy_long",16'h2468, 3, 4, 3, 45, -1, 0);

    for (int r = 0; r < 10; r++) begin
      wc  = $urandom_range(0, 6);
      wce = (wc == 0) ? 32 : wc;
      gap = $urandom_range(0, 31);
      nf  = ($urandom_range(0, 1) == 1) ? wce : $urandom_range(0, wce + 1);
      bl  = $urandom_range(1, 45);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 1 + gap + WORD_CLKS * (wce + 1)) : -1;
      pk  = $urandom_range(1, 100);
      run_msg($sformatf("rnd%0d", r), 16'($urandom), wc, gap, nf, bl, ab, pk);
    end

    // reset in the middle of a data-word slot
    for (int i = 0; i < 4; i++) fifo_mem[(rd_ptr + i) % FDEPTH] = 16'($urandom);
    wr_ptr = rd_ptr + 4;
    b_dw = dw_t.size();
    msg_status = 16'h3c3c; msg_wc = 5'd4; msg_gap = 5'd0; busy_len = 10;
    msg_start = 1'b1;
    tick();
    msg_start = 1'b0;
    guard = 0;
    while (dw_t.size() == b_dw && guard < 200) begin tick(); guard++; end
    if (guard >= 200) chk("rst_wait_dw", 0, 1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {26'd0, dw_rd, tx_csw, tx_dw, msg_busy, msg_done, msg_err}, 0);
    chk("midrst_dword", tx_dword, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    b_csw = csw_t.size(); b_dw = dw_t.size(); b_done = done_t.size(); b_rd = rd_n;
    repeat (150) tick();
    chk("post_rst_csw", csw_t.size() - b_csw, 0);
    chk("post_rst_dw", dw_t.size() - b_dw, 0);
    chk("post_rst_done", done_t.size() - b_done, 0);
    chk("post_rst_rd", rd_n - b_rd, 0);
    chk("post_rst_busy", msg_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
